evaluate_dispatch: RTL and testbench
====================================

Name: evaluate_dispatch

Overview:
Front end and collector for the evaluation terms. It accepts one board and castle mask from the search side, registers it, and clears the bank of evaluator blocks. It then presents the board to them and waits for each evaluator to raise its eval_valid. Finally it captures every eval_mg term, sums them, saturates the total, and returns one signed score through a valid/ready handshake.

Parameters:
EVAL_WIDTH, 32, width of each signed evaluator term and of the result.
NUM_EVAL, 4, number of evaluator blocks attached (1..16).
TIMEOUT, 63, cycles allowed in EVAL before aborting with error.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  search side offers a board
in_ready  out  1  dispatcher can accept a board
in_board  in  `BOARD_WIDTH  board to evaluate
in_castle_mask  in  4  castle rights for in_board
board_valid  out  1  board/castle_mask stable and valid to evaluators
board  out  `BOARD_WIDTH  registered board driven to evaluators
castle_mask  out  4  registered castle mask driven to evaluators
clear_eval  out  1  one-cycle pulse to reset evaluator latency state
eval_valid_vec  in  NUM_EVAL  eval_valid from each evaluator (held high until clear_eval)
eval_mg_vec  in  NUM_EVAL*EVAL_WIDTH  packed signed eval_mg, evaluator i at [i*EVAL_WIDTH +: EVAL_WIDTH]
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
out_eval  out  EVAL_WIDTH  signed saturated sum
out_error  out  1  result aborted by timeout (out_eval forced 0)

Behaviour:
- FSM states: IDLE, CLEAR, EVAL, SUM, DONE.
- Reset (synchronous) sends the FSM to IDLE from any state, including mid-EVAL. Reset drives in_ready=0 for that cycle. It clears out_valid, board_valid, clear_eval, out_error, out_eval, the done bits and the timeout counter to 0. board and castle_mask reset to 0.
- IDLE: in_ready=1. On in_valid&in_ready, register in_board and in_castle_mask and go to CLEAR. board/castle_mask then stay stable until the next acceptance.
- CLEAR: exactly one cycle. clear_eval=1, board_valid=0. Any eval_valid_vec bits seen here are stale and ignored. Next state is EVAL.
- EVAL: board_valid=1 for every cycle in this state.
  - Per evaluator i, a sticky done[i] is set on the first cycle eval_valid_vec[i]=1. In that same cycle term[i] captures eval_mg_vec[i]. Later changes to that input are ignored.
  - Leave EVAL for SUM on the cycle after all done bits are 1. Evaluators may finish in any order or all in the same cycle.
  - The timeout counter starts at 0 on entry and increments each EVAL cycle. If it reaches TIMEOUT with done not all 1, go to DONE with out_error=1 and out_eval=0.
- SUM: one cycle. board_valid drops to 0.
  - Sign-extend every term to EVAL_WIDTH+$clog2(NUM_EVAL)+1 bits and add them.
  - Saturate to EVAL_WIDTH: clamp to max positive 2^(EVAL_WIDTH-1)-1 or min negative -2^(EVAL_WIDTH-1).
  - Register the result into out_eval with out_error=0, then go to DONE.
- DONE: out_valid=1. out_eval and out_error are held stable while out_valid=1 && out_ready=0. On out_ready, clear out_valid, clear the done bits and go to IDLE. in_ready stays 0 until IDLE, so there is no overlap between boards.
- Latency with evaluators of fixed latency L (board_valid high to eval_valid high):
  - acceptance at cycle 0;
  - clear_eval at cycle 1;
  - board_valid from cycle 2;
  - eval_valid at cycle 2+L;
  - SUM at cycle 3+L;
  - out_valid at cycle 4+L.
  With out_ready held high, the next board is accepted at cycle 5+L.
- NUM_EVAL=1 means the sum is the single term, still saturated and still going through SUM.

Test Plan:
- Reset, then one board; 4 evaluators of latency 11 return +100, -30, +5, 0 -> clear_eval pulse at cycle 1, out_valid at cycle 15, out_eval=75, out_error=0.
- Staggered returns: evaluator 2 at EVAL cycle 3, evaluator 0 at cycle 9, evaluators 1 and 3 at cycle 12. Each eval_mg changes after its own eval_valid rises -> captured values used, SUM one cycle after last valid.
- Saturation with EVAL_WIDTH=16: four terms of +20000 -> out_eval=32767. Four terms of -20000 -> out_eval=-32768.
- Timeout: evaluator 3 never asserts eval_valid -> DONE after 63 EVAL cycles, out_valid=1, out_error=1, out_eval=0. The next board then completes normally.
- Backpressure: out_ready low for 20 cycles -> out_valid/out_eval stable, in_ready=0 throughout. Accept and return to IDLE in the cycle after out_ready=1.
- Reset asserted mid-EVAL -> next cycle in IDLE, board_valid=0, out_valid=0. Stale eval_valid_vec=all-1 during the following CLEAR -> ignored, no premature SUM.

Source files
------------

// File: rtl/evaluate_dispatch.sv
// Evaluation front end: latches one board, clears and drives the
// evaluator bank, collects every term, then returns a saturated sum.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   in_*            board offer from search (valid/ready)
//   board_valid     board/castle_mask valid to the evaluators
//   board           registered board to the evaluators
//   castle_mask     registered castle rights to the evaluators
//   clear_eval      one-cycle pulse that restarts the evaluators
//   eval_valid_vec  per-evaluator done flags
//   eval_mg_vec     packed signed per-evaluator terms
//   out_*           saturated score and timeout flag (valid/ready)

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module evaluate_dispatch #(
  parameter int EVAL_WIDTH = 32,
  parameter int NUM_EVAL   = 4,
  parameter int TIMEOUT    = 63
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [`BOARD_WIDTH-1:0]        in_board,
  input  logic [3:0]                     in_castle_mask,
  output logic                           board_valid,
  output logic [`BOARD_WIDTH-1:0]        board,
  output logic [3:0]                     castle_mask,
  output logic                           clear_eval,
  input  logic [NUM_EVAL-1:0]            eval_valid_vec,
  input  logic [NUM_EVAL*EVAL_WIDTH-1:0] eval_mg_vec,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EVAL_WIDTH-1:0]          out_eval,
  output logic                           out_error
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_SUM   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Sum width leaves room for NUM_EVAL terms plus a sign guard bit.
  localparam int SW = EVAL_WIDTH + $clog2(NUM_EVAL) + 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-EVAL_WIDTH+1){1'b0}}, {(EVAL_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-EVAL_WIDTH+1){1'b1}}, {(EVAL_WIDTH-1){1'b0}}};

  logic [2:0]                r_state;
  logic [`BOARD_WIDTH-1:0]   r_board;
  logic [3:0]                r_castle;
  logic [NUM_EVAL-1:0]       r_done;
  logic [CW-1:0]             r_cnt;
  logic [EVAL_WIDTH-1:0]     r_out_eval;
  logic                      r_out_error;
  logic [EVAL_WIDTH-1:0]     r_term [NUM_EVAL];

  logic [NUM_EVAL-1:0]       w_done_nxt;
  logic                      w_all_done;
  logic signed [SW-1:0]      w_sum;
  logic [EVAL_WIDTH-1:0]     w_sat;

  assign in_ready    = (r_state == S_IDLE) && !reset;
  assign clear_eval  = (r_state == S_CLEAR);
  assign board_valid = (r_state == S_EVAL);
  assign out_valid   = (r_state == S_DONE);
  assign board       = r_board;
  assign castle_mask = r_castle;
  assign out_eval    = r_out_eval;
  assign out_error   = r_out_error;

  // Counting this cycle's flags lets SUM follow the last valid directly.
  assign w_done_nxt = r_done | eval_valid_vec;
  assign w_all_done = &w_done_nxt;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_EVAL; i++) begin
      w_sum = w_sum +
        {{(SW-EVAL_WIDTH){r_term[i][EVAL_WIDTH-1]}}, r_term[i]};
    end
  end

  always_comb begin
    w_sat = w_sum[EVAL_WIDTH-1:0];
    if (w_sum > SAT_MAX) begin
      w_sat = SAT_MAX[EVAL_WIDTH-1:0];
    end else if (w_sum < SAT_MIN) begin
      w_sat = SAT_MIN[EVAL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_board     <= '0;
      r_castle    <= '0;
      r_done      <= '0;
      r_cnt       <= '0;
      r_out_eval  <= '0;
      r_out_error <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_board  <= in_board;
            r_castle <= in_castle_mask;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          // Flags seen here belong to the previous board.
          r_done  <= '0;
          r_cnt   <= '0;
          r_state <= S_EVAL;
        end
        S_EVAL: begin
          r_done <= w_done_nxt;
          if (w_all_done) begin
            r_state <= S_SUM;
          end else if (r_cnt == TMO_LAST) begin
            r_out_eval  <= '0;
            r_out_error <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_SUM: begin
          r_out_eval  <= w_sat;
          r_out_error <= 1'b0;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_done  <= '0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Each term is captured only on its evaluator's first valid cycle.
  always_ff @(posedge clk) begin
    if (r_state == S_EVAL) begin
      for (int i = 0; i < NUM_EVAL; i++) begin
        if (eval_valid_vec[i] && !r_done[i]) begin
          r_term[i] <= eval_mg_vec[i*EVAL_WIDTH +: EVAL_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_evaluate_dispatch.sv
// Directed bench for evaluate_dispatch (16-bit terms, 4 evaluators).
// Bench-modelled evaluators with per-unit latency and late data churn.

`ifndef BOARD_WIDTH
`define BOARD_WIDTH 64
`endif

module tb_evaluate_dispatch;

  localparam int W     = 16;
  localparam int N     = 4;
  localparam int TMO   = 63;
  localparam int NEVER = 1000;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    in_valid;
  logic                    in_ready;
  logic [`BOARD_WIDTH-1:0] in_board;
  logic [3:0]              in_castle_mask;
  logic                    board_valid;
  logic [`BOARD_WIDTH-1:0] board;
  logic [3:0]              castle_mask;
  logic                    clear_eval;
  logic [N-1:0]            eval_valid_vec;
  logic [N*W-1:0]          eval_mg_vec;
  logic                    out_valid;
  logic                    out_ready;
  logic [W-1:0]            out_eval;
  logic                    out_error;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  evaluate_dispatch #(
    .EVAL_WIDTH(W),
    .NUM_EVAL  (N),
    .TIMEOUT   (TMO)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_board      (in_board),
    .in_castle_mask(in_castle_mask),
    .board_valid   (board_valid),
    .board         (board),
    .castle_mask   (castle_mask),
    .clear_eval    (clear_eval),
    .eval_valid_vec(eval_valid_vec),
    .eval_mg_vec   (eval_mg_vec),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_eval      (out_eval),
    .out_error     (out_error)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Cycle 0 is the acceptance cycle; evaluator i raises valid at
  // cycle 2+lat_i and its data turns to garbage afterwards.
  task automatic run_board(input logic [63:0] b, input logic [3:0] m,
                           input int l0, input int l1,
                           input int l2, input int l3,
                           input int v0, input int v1,
                           input int v2, input int v3,
                           input int rdly, input bit stale,
                           input int exp_cyc, input int exp_val,
                           input bit exp_err);
    int lat [4];
    logic [W-1:0] val [4];
    logic [W-1:0] e16;
    int ov_cyc;
    lat = '{l0, l1, l2, l3};
    val = '{W'(v0), W'(v1), W'(v2), W'(v3)};
    e16 = W'(exp_val);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid       = 1'b1;
    in_board       = b;
    in_castle_mask = m;
    eval_valid_vec = stale ? '1 : '0;
    eval_mg_vec    = '1;
    ov_cyc = -1;
    for (int c = 1; c < 200 && ov_cyc < 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 1) begin
        chk("clear_pulse", clear_eval, 1);
        chk("bv_in_clear", board_valid, 0);
      end
      if (c == 2) begin
        chk("bv_rise", board_valid, 1);
        chk("clear_drop", clear_eval, 0);
        chk("board_out", board, b);
        chk("castle_out", castle_mask, m);
      end
      if (out_valid) begin
        ov_cyc = c;
        eval_valid_vec = '0;
      end else begin
        for (int i = 0; i < N; i++) begin
          eval_valid_vec[i] = (c >= 2 + lat[i]) || (stale && c == 1);
          eval_mg_vec[i*W +: W] = (c == 2 + lat[i]) ? val[i] : ~val[i];
        end
      end
    end
    chk("out_valid_cycle", ov_cyc, exp_cyc);
    chk("out_eval", out_eval, e16);
    chk("out_error", out_error, exp_err);
    chk("in_ready_done", in_ready, 0);
    for (int k = 0; k < rdly; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_eval", out_eval, e16);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle", in_ready, 1);
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b0;
    in_board       = '0;
    in_castle_mask = '0;
    eval_valid_vec = '0;
    eval_mg_vec    = '0;
    out_ready      = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_bv", board_valid, 0);
    chk("rst_clear", clear_eval, 0);
    chk("rst_eval", out_eval, 0);
    chk("rst_error", out_error, 0);
    chk("rst_board", board, 0);
    reset = 1'b0;

    // latency 11: 100-30+5+0
    run_board(64'h0123_4567_89ab_cdef, 4'hf, 11, 11, 11, 11,
              100, -30, 5, 0, 0, 0, 15, 75, 0);
    // staggered: last valid at EVAL cycle 12
    run_board(64'hdead_beef_0000_1111, 4'h5, 9, 12, 3, 12,
              7, -300, 1234, 50, 0, 0, 16, 991, 0);
    // positive and negative saturation
    run_board(64'h1, 4'h1, 1, 1, 1, 1,
              20000, 20000, 20000, 20000, 0, 0, 5, 32767, 0);
    run_board(64'h2, 4'h2, 1, 1, 1, 1,
              -20000, -20000, -20000, -20000, 0, 0, 5, -32768, 0);
    // evaluator 3 never answers
    run_board(64'h3, 4'h3, 0, 0, 0, NEVER,
              1, 1, 1, 1, 0, 0, 2 + TMO, 0, 1);
    // zero latency afterwards
    run_board(64'h4, 4'h4, 0, 0, 0, 0,
              1, 2, 3, 4, 0, 0, 4, 10, 0);
    // backpressure for 20 cycles
    run_board(64'h5, 4'h8, 2, 2, 2, 2,
              -5, -5, -5, -5, 20, 0, 6, -20, 0);

    // reset in the middle of EVAL
    @(negedge clk);
    in_valid = 1'b1;
    in_board = 64'h6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_bv", board_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_in_ready", in_ready, 0);
    chk("mr_bv", board_valid, 0);
    chk("mr_out_valid", out_valid, 0);
    reset = 1'b0;
    #1;
    chk("mr_idle", in_ready, 1);

    // stale all-ones flags during CLEAR
    run_board(64'h7, 4'hc, 3, 3, 3, 3,
              10, 20, 30, 40, 0, 1, 7, 100, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
